prog_fetch: RTL and testbench

//  Instruction fetch unit: the requesting side of the program memory (Psize-bit address in,
//  (Isize+1)-bit instruction out, combinational read). Owns the program counter (PC), drives

---
 rtl/prog_fetch.sv | 150 +++++++++++++++
 tb/tb_prog_fetch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_fetch.sv
// prog_fetch: instruction fetch unit.
// Owns the program counter, presents it to a combinational program memory,
// captures the returned word into an instruction register and hands it to the
// decoder over a valid/ready handshake. Supports stall, redirect, halt/start
// and, when PROG_FETCH_RSTACK_EN is defined, a call/return stack.
module prog_fetch #(
    parameter int Psize   = 6,
    parameter int Isize   = 24,
    parameter int RSDEPTH = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic             halt_req,
    output logic [Psize-1:0] address,
    input  logic [Isize:0]   I,
    output logic [Isize:0]   ir,
    output logic [Psize-1:0] ir_pc,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             redirect_en,
    input  logic [Psize-1:0] redirect_addr,
    input  logic             call_en,
    input  logic [Psize-1:0] call_target,
    input  logic             ret_en,
    output logic             running,
    output logic             rs_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t           state, state_nxt;
    logic [Psize-1:0] pc;
    logic             jump;        // flush-type event accepted this cycle
    logic [Psize-1:0] jump_target;
    logic             load;

`ifdef PROG_FETCH_RSTACK_EN
    localparam int SPW = $clog2(RSDEPTH + 1);
    localparam int IW  = (RSDEPTH > 1) ? $clog2(RSDEPTH) : 1;

    logic [Psize-1:0] rstack [RSDEPTH];
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   top_idx;
    logic             push, pop, rs_full, rs_empty;

    assign rs_full  = (sp == SPW'(RSDEPTH));
    assign rs_empty = (sp == '0);
    assign top_idx  = sp - 1'b1;
`else
    // Without the stack a return has nothing to return to.
    logic unused_ret_en;
    localparam int unused_rsdepth = RSDEPTH;
    assign unused_ret_en = ret_en;
    assign rs_err        = 1'b0;
`endif

    assign address = pc;
    assign running = (state == S_RUN);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Run-control transitions; halt_req takes precedence over start.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !halt_req) state_nxt = S_RUN;
            S_RUN:   if (halt_req)           state_nxt = S_HALT;
            S_HALT:  if (start && !halt_req) state_nxt = S_RUN;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    // Control-flow change decode: redirect beats call beats return; ignored in IDLE.
    always_comb begin
        jump        = 1'b0;
        jump_target = pc;
`ifdef PROG_FETCH_RSTACK_EN
        push = 1'b0;
        pop  = 1'b0;
`endif
        if (state != S_IDLE) begin
            if (redirect_en) begin
                jump        = 1'b1;
                jump_target = redirect_addr;
            end else if (call_en) begin
                jump        = 1'b1;
                jump_target = call_target;
`ifdef PROG_FETCH_RSTACK_EN
                push        = 1'b1;
            end else if (ret_en) begin
                jump        = 1'b1;
                pop         = 1'b1;
                jump_target = rs_empty ? '0 : rstack[top_idx[IW-1:0]];
`endif
            end
        end
    end

    assign load = (state == S_RUN) && (!ir_valid || ir_ready) && !jump;

    // PC and instruction register: flush on jump, fetch on load, drop on consume.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (jump) begin
            pc       <= jump_target;
            ir_valid <= 1'b0;
        end else if (load) begin
            ir       <= I;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc + 1'b1;
        end else if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
        end
    end

`ifdef PROG_FETCH_RSTACK_EN
    // Stack pointer and sticky overflow/underflow flag.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sp     <= '0;
            rs_err <= 1'b0;
        end else if (push) begin
            if (rs_full) rs_err <= 1'b1;
            else         sp     <= sp + 1'b1;
        end else if (pop) begin
            if (rs_empty) rs_err <= 1'b1;
            else          sp     <= sp - 1'b1;
        end
    end

    // Return-address storage; writes the slot just above the current top.
    // NOTE: stack entries are not reset; sp guards every read so stale contents are never used.
    always_ff @(posedge clk) begin
        if (push && !rs_full) rstack[sp[IW-1:0]] <= ir_pc + 1'b1;
    end
`endif

endmodule

// File: tb/tb_prog_fetch.sv
// tb_prog_fetch: directed self-checking bench for prog_fetch.
// Program memory model: word at address a is {a, ~a, 13'h1ACE}.
module tb_prog_fetch;

    localparam int PS = 6;
    localparam int IS = 24;

    logic          clk = 1'b0;
    logic          nReset, start, halt_req, ir_ready;
    logic          redirect_en, call_en, ret_en;
    logic [PS-1:0] address, redirect_addr, call_target, ir_pc;
    logic [IS:0]   i_bus, ir;
    logic          ir_valid, running, rs_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [IS:0] mem_word(input logic [PS-1:0] a);
        return {a, ~a, 13'h1ACE};
    endfunction

    assign i_bus = mem_word(address);

    prog_fetch #(.Psize(PS), .Isize(IS), .RSDEPTH(4)) dut (
        .clk(clk), .nReset(nReset), .start(start), .halt_req(halt_req),
        .address(address), .I(i_bus), .ir(ir), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .call_en(call_en), .call_target(call_target), .ret_en(ret_en),
        .running(running), .rs_err(rs_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nReset = 1'b0; start = 1'b0; halt_req = 1'b0; ir_ready = 1'b1;
        redirect_en = 1'b0; redirect_addr = '0; call_en = 1'b0; call_target = '0; ret_en = 1'b0;
        #12;
        checks++;
        if ({address, ir, ir_pc, ir_valid, running, rs_err} !== '0) begin
            $display("FAIL reset_outputs: got addr=%0d ir=%h ir_pc=%0d v=%b run=%b err=%b, expected all 0",
                     address, ir, ir_pc, ir_valid, running, rs_err);
            errors++;
        end
        @(negedge clk) nReset = 1'b1;
        tick;
        checks++;
        if ({running, ir_valid, address} !== {2'b00, 6'd0}) begin
            $display("FAIL idle_no_start: got run=%b v=%b addr=%0d, expected 0 0 0", running, ir_valid, address);
            errors++;
        end
    endtask

    task automatic test_stream;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({running, ir_valid} !== 2'b10) begin
            $display("FAIL start_accept: got run=%b v=%b, expected 1 0", running, ir_valid);
            errors++;
        end
        for (int k = 0; k < 3; k++) begin
            logic [PS-1:0] p;
            p = PS'(k);
            tick;
            checks++;
            if ({ir_valid, ir_pc, ir, address} !== {1'b1, p, mem_word(p), p + 6'd1}) begin
                $display("FAIL stream_%0d: got v=%b pc=%0d ir=%h addr=%0d, expected pc=%0d ir=%h addr=%0d",
                         k, ir_valid, ir_pc, ir, address, p, mem_word(p), p + 6'd1);
                errors++;
            end
        end
    endtask

    task automatic test_wrap;
        repeat (59) tick;
        for (int k = 0; k < 4; k++) begin
            logic [PS-1:0] p;
            p = PS'(62 + k);
            tick;
            checks++;
            if ({ir_valid, ir_pc, ir} !== {1'b1, p, mem_word(p)}) begin
                $display("FAIL wrap_%0d: got v=%b pc=%0d ir=%h, expected pc=%0d", k, ir_valid, ir_pc, ir, p);
                errors++;
            end
        end
    endtask

    task automatic test_stall;
        repeat (4) tick;
        checks++;
        if ({ir_valid, ir_pc} !== {1'b1, 6'd5}) begin
            $display("FAIL stall_pre: got v=%b pc=%0d, expected 1 5", ir_valid, ir_pc);
            errors++;
        end
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if ({ir_valid, ir_pc, ir, address} !== {1'b1, 6'd5, mem_word(6'd5), 6'd6}) begin
                $display("FAIL stall_hold_%0d: got v=%b pc=%0d ir=%h addr=%0d, expected 1 5 %h 6",
                         k, ir_valid, ir_pc, ir, address, mem_word(6'd5));
                errors++;
            end
        end
        ir_ready = 1'b1;
        tick;
        checks++;
        if ({ir_valid, ir_pc, ir} !== {1'b1, 6'd6, mem_word(6'd6)}) begin
            $display("FAIL stall_resume: got v=%b pc=%0d, expected 1 6", ir_valid, ir_pc);
            errors++;
        end
    endtask

    task automatic test_redirect;
        redirect_en = 1'b1; redirect_addr = 6'd2;
        tick;
        redirect_en = 1'b0;
        tick;
        tick;
        checks++;
        if ({ir_valid, ir_pc} !== {1'b1, 6'd3}) begin
            $display("FAIL redir_setup: got v=%b pc=%0d, expected 1 3", ir_valid, ir_pc);
            errors++;
        end
        redirect_en = 1'b1; redirect_addr = 6'd20;
        call_en = 1'b1; call_target = 6'd40;
        tick;
        redirect_en = 1'b0; call_en = 1'b0;
        checks++;
        if ({ir_valid, address} !== {1'b0, 6'd20}) begin
            $display("FAIL redir_flush: got v=%b addr=%0d, expected 0 20", ir_valid, address);
            errors++;
        end
        tick;
        checks++;
        if ({ir_valid, ir_pc, ir} !== {1'b1, 6'd20, mem_word(6'd20)}) begin
            $display("FAIL redir_target: got v=%b pc=%0d, expected 1 20", ir_valid, ir_pc);
            errors++;
        end
        tick;
        checks++;
        if ({ir_valid, ir_pc} !== {1'b1, 6'd21}) begin
            $display("FAIL redir_next: got v=%b pc=%0d, expected 1 21", ir_valid, ir_pc);
            errors++;
        end
    endtask

`ifdef PROG_FETCH_RSTACK_EN
    task automatic test_call_ret;
        logic [PS-1:0] pops [5];
        pops[0] = 6'd43; pops[1] = 6'd42; pops[2] = 6'd41; pops[3] = 6'd9; pops[4] = 6'd0;
        redirect_en = 1'b1; redirect_addr = 6'd7;
        tick;
        redirect_en = 1'b0;
        tick;
        call_en = 1'b1; call_target = 6'd30;
        tick;
        call_en = 1'b0;
        checks++;
        if ({ir_valid, address} !== {1'b0, 6'd30}) begin
            $display("FAIL call_flush: got v=%b addr=%0d, expected 0 30", ir_valid, address);
            errors++;
        end
        tick;
        tick;
        ret_en = 1'b1;
        tick;
        ret_en = 1'b0;
        tick;
        checks++;
        if ({ir_valid, ir_pc} !== {1'b1, 6'd8}) begin
            $display("FAIL ret_target: got v=%b pc=%0d, expected 1 8", ir_valid, ir_pc);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            call_en = 1'b1; call_target = PS'(40 + i);
            tick;
            call_en = 1'b0;
            tick;
            checks++;
            if (rs_err !== (i == 4)) begin
                $display("FAIL nest_err_%0d: got %b expected %b", i, rs_err, (i == 4));
                errors++;
            end
        end
        ret_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if ({ir_valid, address, rs_err} !== {1'b0, pops[i], 1'b1}) begin
                $display("FAIL pop_%0d: got v=%b addr=%0d err=%b, expected 0 %0d 1",
                         i, ir_valid, address, rs_err, pops[i]);
                errors++;
            end
        end
        ret_en = 1'b0;
        tick;
        checks++;
        if ({ir_valid, ir_pc} !== {1'b1, 6'd0}) begin
            $display("FAIL underflow_fetch: got v=%b pc=%0d, expected 1 0", ir_valid, ir_pc);
            errors++;
        end
    endtask
`else
    task automatic test_call_ret;
        call_en = 1'b1; call_target = 6'd30;
        tick;
        call_en = 1'b0;
        checks++;
        if ({ir_valid, address} !== {1'b0, 6'd30}) begin
            $display("FAIL call_flush: got v=%b addr=%0d, expected 0 30", ir_valid, address);
            errors++;
        end
        tick;
        checks++;
        if ({ir_valid, ir_pc} !== {1'b1, 6'd30}) begin
            $display("FAIL call_target: got v=%b pc=%0d, expected 1 30", ir_valid, ir_pc);
            errors++;
        end
        ret_en = 1'b1;
        tick;
        ret_en = 1'b0;
        checks++;
        if ({ir_valid, ir_pc, rs_err} !== {1'b1, 6'd31, 1'b0}) begin
            $display("FAIL ret_ignored: got v=%b pc=%0d err=%b, expected 1 31 0", ir_valid, ir_pc, rs_err);
            errors++;
        end
    endtask
`endif

    task automatic test_halt_reset;
        redirect_en = 1'b1; redirect_addr = 6'd10;
        tick;
        redirect_en = 1'b0;
        tick;
        ir_ready = 1'b0; halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        checks++;
        if ({running, ir_valid, ir_pc, address} !== {2'b01, 6'd10, 6'd11}) begin
            $display("FAIL halt_enter: got run=%b v=%b pc=%0d addr=%0d, expected 0 1 10 11",
                     running, ir_valid, ir_pc, address);
            errors++;
        end
        repeat (2) tick;
        checks++;
        if ({running, ir_valid, ir_pc, address} !== {2'b01, 6'd10, 6'd11}) begin
            $display("FAIL halt_hold: got run=%b v=%b pc=%0d addr=%0d, expected 0 1 10 11",
                     running, ir_valid, ir_pc, address);
            errors++;
        end
        nReset = 1'b0;
        #1;
        checks++;
        if ({address, ir, ir_pc, ir_valid, running, rs_err} !== '0) begin
            $display("FAIL async_reset: got addr=%0d ir=%h pc=%0d v=%b run=%b err=%b, expected all 0",
                     address, ir, ir_pc, ir_valid, running, rs_err);
            errors++;
        end
        ir_ready = 1'b1;
        @(negedge clk) nReset = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        checks++;
        if ({running, ir_valid, ir_pc, ir} !== {2'b11, 6'd0, mem_word(6'd0)}) begin
            $display("FAIL restart: got run=%b v=%b pc=%0d, expected 1 1 0", running, ir_valid, ir_pc);
            errors++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_stream;
        test_wrap;
        test_stall;
        test_redirect;
        test_call_ret;
        test_halt_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
